imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Boot-time controller that fills the single-cycle core's 64-word instruction memory from a byte stream. It replaces hard-coded program images. It runs a framed load protocol: length byte, little-endian instruction words, XOR checksum byte. Each assembled word is written into the instruction memory write port. The core is held in reset until a load completes with a valid checksum.

Parameters:
ADDR_W, 6, instruction memory word-address width (64 words)
MAX_WORDS, 64, largest legal word count in a frame (must be ≤ 2^ADDR_W and ≤ 255)
TIMEOUT_CYC, 1024, idle cycles allowed between accepted bytes before the load aborts

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR
rx_data  in  8  stream byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a clock edge
mem_we  out  1  instruction memory write enable, one-cycle pulse per word
mem_waddr  out  ADDR_W  word index being written
mem_wdata  out  32  assembled instruction word
cpu_rst  out  1  reset to the core; high except in DONE
busy  out  1  high in LEN, DATA, WRITE, CSUM
done  out  1  high in DONE
err_code  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout; valid in ERROR, otherwise 00

Behaviour:
- Reset (any state, including mid-load): state=IDLE. Outputs: rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err_code=00. Internal regs: byte/word counters, checksum, shift register and timeout counter all cleared.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE: rx_ready=0. start → LEN; clear counters, checksum=0, err_code=00.
- LEN: rx_ready=1. On transfer, latch N=rx_data.
  - N==0 or N>MAX_WORDS → ERROR, code 01.
  - Otherwise → DATA with byte_idx=0, word_idx=0.
  - The length byte is excluded from the checksum.
- DATA: rx_ready=1. Each transfer XORs the byte into the checksum. The byte is placed at bits [8*byte_idx+7 : 8*byte_idx] (little-endian), then byte_idx increments. The transfer with byte_idx==3 → WRITE.
- WRITE (exactly 1 cycle): rx_ready=0, mem_we=1, mem_waddr=word_idx, mem_wdata=assembled word.
  - Next: word_idx+1; byte_idx=0.
  - If word_idx==N-1 → CSUM, else → DATA.
- CSUM: rx_ready=1. On transfer: rx_data==checksum → DONE, else → ERROR code 10.
- DONE: cpu_rst=0, done=1. Holds until start or rst.
- ERROR: cpu_rst=1, err_code held. Holds until start or rst.
- start in DONE/ERROR → LEN, with cpu_rst reasserted in the same cycle LEN is entered. start in LEN/DATA/WRITE/CSUM is ignored.
- Timeout: counter clears on every transfer and on entry to LEN. It increments each cycle in LEN/DATA/CSUM without a transfer. Reaching TIMEOUT_CYC-1 with no transfer that cycle → ERROR code 11. The counter is frozen in WRITE.
- mem_waddr/mem_wdata keep their last values outside WRITE. mem_we is 0 everywhere except WRITE.
- Throughput: 4 cycles minimum per word plus 1 WRITE cycle. Frame minimum latency from start = 1 + 5N + 1 cycles to DONE, with rx_valid held high.
- Memory contents beyond N are not touched. Partial loads before ERROR leave already-written words in memory.

Test Plan:
- Load N=2, bytes B3 00 50 00 33 01 50 00, checksum 81, rx_valid always high → mem_we pulses at addr 0 with 0x005000B3 and addr 1 with 0x00500133; DONE; cpu_rst falls to 0, done=1.
- Same frame with checksum 80 → both words written, then ERROR, err_code=10, cpu_rst stays 1.
- Length byte 00, then length 0x41 (65) → ERROR code 01 immediately after the length transfer; mem_we never asserted.
- Stall: after 3 data bytes, drop rx_valid for TIMEOUT_CYC cycles → ERROR code 11. A subsequent start plus a valid N=1 frame (13 00 00 00, csum 13) → DONE.
- Throttled source: rx_valid toggles every other cycle during the N=2 frame → identical writes and checksum result; no byte dropped or duplicated; rx_ready=0 during WRITE cycles.
- Assert rst in the middle of DATA, then start with a fresh N=1 frame → outputs at reset values; the new word lands at addr 0 with byte order correct, unaffected by the partially assembled word.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Stream-in / memory-write bus between the byte source, the boot loader and
// the instruction memory write port.
//
// Handshake: a byte moves from source to loader exactly on a rising clk edge
// where rx_valid && rx_ready are both high. The source keeps rx_data stable
// while rx_valid is high and not yet accepted. rx_ready depends only on the
// loader state, never on rx_valid. mem_we is a one-cycle, unacknowledged
// write strobe qualified by mem_waddr/mem_wdata.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Source / memory side.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image (length byte, little-endian
// 32-bit words, XOR checksum of the word bytes) and writes each word into the
// instruction memory. The core stays in reset until a frame completes with a
// matching checksum.
module imem_boot_loader #(
    parameter int ADDR_W      = 6,
    parameter int MAX_WORDS   = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code,
    output logic [2:0]          state_dbg
);
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q;
    logic [1:0]        byte_q;
    logic [ADDR_W-1:0] word_q;
    logic [7:0]        csum_q;
    logic [23:0]       shift_q;     // low three bytes of the word being assembled
    logic [TMO_W-1:0]  tmo_q;
    logic [1:0]        err_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    logic xfer, tmo_hit, len_bad, last_word, csum_ok;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign tmo_hit   = (tmo_q == TMO_LAST) && !xfer;
    assign len_bad   = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN);
    assign last_word = (8'(word_q) == (len_q - 8'd1));
    assign csum_ok   = (bus.rx_data == csum_q);

    assign bus.rx_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst       = (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign busy          = bus.rx_ready || (state_q == S_WRITE);
    assign err_code      = (state_q == S_ERROR) ? err_q : 2'b00;
    assign state_dbg     = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode for the frame protocol.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LEN;
            S_LEN: begin
                if (xfer)         state_d = len_bad ? S_ERROR : S_DATA;
                else if (tmo_hit) state_d = S_ERROR;
            end
            S_DATA: begin
                if (xfer && (byte_q == 2'd3)) state_d = S_WRITE;
                else if (tmo_hit)             state_d = S_ERROR;
            end
            S_WRITE: state_d = last_word ? S_CSUM : S_DATA;
            S_CSUM: begin
                if (xfer)         state_d = csum_ok ? S_DONE : S_ERROR;
                else if (tmo_hit) state_d = S_ERROR;
            end
            S_DONE, S_ERROR: if (start) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, checksum, word assembly, timeout and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            shift_q <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        byte_q <= '0;
                        word_q <= '0;
                        csum_q <= '0;
                        tmo_q  <= '0;
                        err_q  <= 2'b00;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len_q  <= bus.rx_data;
                        tmo_q  <= '0;
                        byte_q <= '0;
                        word_q <= '0;
                        if (len_bad) err_q <= 2'b01;
                    end else if (tmo_hit) begin
                        err_q <= 2'b11;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ bus.rx_data;
                        tmo_q  <= '0;
                        byte_q <= byte_q + 2'd1;
                        case (byte_q)
                            2'd0: shift_q[7:0]   <= bus.rx_data;
                            2'd1: shift_q[15:8]  <= bus.rx_data;
                            2'd2: shift_q[23:16] <= bus.rx_data;
                            default: begin
                                waddr_q <= word_q;
                                wdata_q <= {bus.rx_data, shift_q};
                            end
                        endcase
                    end else if (tmo_hit) begin
                        err_q <= 2'b11;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    word_q <= word_q + 1'b1;
                end
                S_CSUM: begin
                    if (xfer) begin
                        tmo_q <= '0;
                        if (!csum_ok) err_q <= 2'b10;
                    end else if (tmo_hit) begin
                        err_q <= 2'b11;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames are built from word lists, the expected
// write sequence and final status are derived from the frame rules, and a
// negedge monitor scores every memory write against the expected queue.
module tb_imem_boot_loader;
    localparam int ADDR_W      = 6;
    localparam int MAX_WORDS   = 64;
    localparam int TIMEOUT_CYC = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cpu_rst, busy, done;
    logic [1:0] err_code;
    logic [2:0] state_dbg;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .err_code(err_code), .state_dbg(state_dbg)
    );

    // clock and cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] word_q[$];
    logic [37:0] exp_q[$];      // {addr, data} of each expected write
    logic [37:0] exp_e;
    int start_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("waddr", 64'(bus.mem_waddr), 64'(exp_e[37:32]));
                check("wdata", 64'(bus.mem_wdata), 64'(exp_e[31:0]));
            end
            check("ready_in_write", 64'(bus.rx_ready), 0);
        end
    end

    // driver: called on a negedge, sends everything in tx_q; mode 0 = always
    // valid, 1 = valid every other cycle, 2 = random valid
    task automatic drive_stream(input int mode, input bit with_start);
        int n = 0;
        bit tog = 1'b1;
        bit v, x;
        start_cyc = cyc;
        start = with_start;
        while (tx_q.size() > 0 && n < 20000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.rx_valid = v;
            bus.rx_data  = v ? tx_q[0] : 8'($urandom);
            x = v && bus.rx_ready;
            @(posedge clk);
            if (x) void'(tx_q.pop_front());
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        bus.rx_valid = 1'b0;
        if (tx_q.size() != 0) begin
            check("drive_budget", 64'(tx_q.size()), 0);
            tx_q.delete();
        end
    endtask

    // reference model: frame bytes, expected writes and outcome from word_q
    task automatic run_frame(input logic [7:0] len, input logic [7:0] delta, input int mode);
        logic [7:0]  x = 8'h00;
        logic [7:0]  bt;
        logic [31:0] w;
        int exp_err, latency, k;
        bit legal;
        legal = (len != 8'd0) && (int'(len) <= MAX_WORDS);
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(len);
        if (legal) begin
            for (int i = 0; i < int'(len); i++) begin
                w = word_q[i];
                for (int b = 0; b < 4; b++) begin
                    bt = w[8*b +: 8];
                    tx_q.push_back(bt);
                    x = x ^ bt;
                end
                exp_q.push_back({6'(i), w});
            end
            tx_q.push_back(x ^ delta);
        end
        exp_err = !legal ? 1 : ((delta != 8'd0) ? 2 : 0);
        drive_stream(mode, 1'b1);
        latency = cyc - start_cyc - 1;
        k = 0;
        while (busy && k < 16) begin @(negedge clk); k++; end
        check("busy_end", 64'(busy), 0);
        check("done", 64'(done), 64'(exp_err == 0));
        check("cpu_rst", 64'(cpu_rst), 64'(exp_err != 0));
        check("err_code", 64'(err_code), 64'(exp_err));
        check("writes_left", 64'(exp_q.size()), 0);
        if (legal && exp_err == 0 && mode == 0)
            check("latency", 64'(latency), 64'(2 + 5 * int'(len)));
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.rx_ready), 0);
        check({tag, "_we"}, 64'(bus.mem_we), 0);
        check({tag, "_waddr"}, 64'(bus.mem_waddr), 0);
        check({tag, "_wdata"}, 64'(bus.mem_wdata), 0);
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 1);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err"}, 64'(err_code), 0);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // reference frame, good and bad checksum
        word_q = '{32'h005000B3, 32'h00500133};
        run_frame(8'd2, 8'h00, 0);
        run_frame(8'd2, 8'h01, 0);

        // illegal lengths
        run_frame(8'd0, 8'h00, 0);
        run_frame(8'd65, 8'h00, 0);

        // stall after three data bytes
        exp_q.delete();
        tx_q = '{8'h01, 8'h13, 8'h00, 8'h00};
        drive_stream(0, 1'b1);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        check("tmo_not_yet_busy", 64'(busy), 1);
        check("tmo_not_yet_err", 64'(err_code), 0);
        @(negedge clk);
        check("tmo_err", 64'(err_code), 3);
        check("tmo_busy", 64'(busy), 0);
        check("tmo_cpu_rst", 64'(cpu_rst), 1);
        word_q = '{32'h00000013};
        run_frame(8'd1, 8'h00, 0);

        // throttled source
        word_q = '{32'h005000B3, 32'h00500133};
        run_frame(8'd2, 8'h00, 1);

        // reset in the middle of a word
        tx_q = '{8'h01, 8'hAA, 8'hBB};
        drive_stream(0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        word_q = '{32'h44332211};
        run_frame(8'd1, 8'h00, 0);

        // largest legal frame with a random source
        word_q.delete();
        for (int i = 0; i < MAX_WORDS; i++) word_q.push_back($urandom);
        run_frame(8'(MAX_WORDS), 8'h00, 2);

        // random frames
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 6);
            word_q.delete();
            for (int i = 0; i < n; i++) word_q.push_back($urandom);
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(8'(n), d, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
